// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter that shares one SPI master transfer engine between
// NUM_REQ requesters. It grants one request, programs the master and starts
// the transfer. It then waits for completion or a timeout and returns the
// result to the granted requester.
module spi_xfer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int CFG_W   = 32,
  parameter int TIMEOUT = 1024,
  localparam int ID_W   = $clog2(NUM_REQ),
  localparam int CNT_W  = $clog2(TIMEOUT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*CFG_W-1:0]  req_config,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_timeout,
  output logic                      busy,
  output logic [DATA_W-1:0]         i_data_m,
  output logic [CFG_W-1:0]          data_config_master,
  output logic                      trans_en,
  input  logic                      interupt_request,
  input  logic [DATA_W-1:0]         o_data_m
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ID_W-1:0]     last_grant;
  logic [ID_W-1:0]     grant;
  logic [ID_W-1:0]     pick;
  logic                pick_found;
  logic [DATA_W-1:0]   data_lat;
  logic [CFG_W-1:0]    cfg_lat;
  logic [CNT_W-1:0]    wait_cnt;
  logic                wait_expired;

  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign busy         = (state != S_IDLE);

  // Round-robin pick: walk from the farthest to the nearest position after
  // last_grant so the nearest requesting index overwrites the others.
  always_comb begin
    int idx;
    idx        = 0;
    pick       = '0;
    pick_found = 1'b0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = (int'(last_grant) + off) % NUM_REQ;
      if (req_valid[idx]) begin
        pick       = ID_W'(idx);
        pick_found = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic plus the combinational accept strobe in IDLE.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      S_IDLE: begin
        if (pick_found) begin
          req_ready[pick] = 1'b1;
          state_nxt       = S_CONFIG;
        end
      end
      S_CONFIG: state_nxt = S_START;
      S_START:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (interupt_request || wait_expired) state_nxt = S_DONE;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch the winner, program the master, time the wait and
  // register the response. The strobes default low so each lasts one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant         <= ID_W'(NUM_REQ - 1);
      grant              <= '0;
      data_lat           <= '0;
      cfg_lat            <= '0;
      wait_cnt           <= '0;
      i_data_m           <= '0;
      data_config_master <= '0;
      trans_en           <= 1'b0;
      rsp_valid          <= 1'b0;
      rsp_id             <= '0;
      rsp_data           <= '0;
      rsp_timeout        <= 1'b0;
    end else begin
      trans_en  <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant    <= pick;
            data_lat <= req_data[int'(pick)*DATA_W +: DATA_W];
            cfg_lat  <= req_config[int'(pick)*CFG_W +: CFG_W];
          end
        end
        S_CONFIG: begin
          i_data_m           <= data_lat;
          data_config_master <= cfg_lat;
          trans_en           <= 1'b1;
        end
        S_START: begin
          wait_cnt <= '0;
        end
        S_WAIT: begin
          if (interupt_request) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= grant;
            rsp_data    <= o_data_m;
            rsp_timeout <= 1'b0;
          end else if (wait_expired) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= grant;
            rsp_data    <= '0;
            rsp_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DONE: begin
          last_grant <= grant;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Scoreboard bench for spi_xfer_arbiter with a simple SPI master model.
module tb_spi_xfer_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int CFG_W   = 32;
  localparam int TIMEOUT = 16;

  typedef struct {
    int         id;
    logic [7:0] data;
    bit         tmo;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*CFG_W-1:0]  req_config;
  logic                      rsp_valid;
  logic [1:0]                rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_timeout;
  logic                      busy;
  logic [DATA_W-1:0]         i_data_m;
  logic [CFG_W-1:0]          data_config_master;
  logic                      trans_en;
  logic                      interupt_request;
  logic [DATA_W-1:0]         o_data_m;

  logic       modelIrq = 1'b0;
  logic       strayIrq = 1'b0;
  logic [7:0] replyMask = 8'h00;
  int         replyDelay = 0;
  int         pend = 0;

  logic [7:0]  txByte  [NUM_REQ];
  logic [31:0] cfgWord [NUM_REQ];

  exp_t sbq[$];
  int   mLast = NUM_REQ - 1;
  int   vectors = 0;
  int   miscompares = 0;
  int   teCount = 0;
  int   teWide = 0;
  int   rspCount = 0;
  logic tePrev = 1'b0;

  spi_xfer_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CFG_W(CFG_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_config(req_config),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .i_data_m(i_data_m), .data_config_master(data_config_master),
    .trans_en(trans_en), .interupt_request(interupt_request),
    .o_data_m(o_data_m)
  );

  always #5 clk = ~clk;

  assign interupt_request = modelIrq | strayIrq;
  assign o_data_m         = i_data_m ^ replyMask;

  // SPI master model: raises a one-cycle interrupt replyDelay cycles after
  // the cycle in which trans_en is seen; replyDelay 0 means never answer.
  always @(posedge clk) begin
    if (rst) begin
      modelIrq <= 1'b0;
      pend     <= 0;
    end else begin
      modelIrq <= 1'b0;
      if (trans_en) begin
        pend <= replyDelay;
        if (replyDelay == 1) modelIrq <= 1'b1;
      end else if (pend > 0) begin
        pend <= pend - 1;
        if (pend == 2) modelIrq <= 1'b1;
      end
    end
  end

  // Counts trans_en pulses, over-long pulses and response strobes.
  always @(negedge clk) begin
    if (trans_en) begin
      teCount++;
      if (tePrev) teWide++;
    end
    tePrev = trans_en;
    if (rsp_valid) rspCount++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int rrPick(input logic [3:0] m);
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (m[(mLast + off) % NUM_REQ]) return (mLast + off) % NUM_REQ;
    end
    return 0;
  endfunction

  task automatic loadData();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data[i*DATA_W +: DATA_W] = txByte[i];
      req_config[i*CFG_W +: CFG_W] = cfgWord[i];
    end
  endtask

  task automatic doReset();
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b0;
    mLast = NUM_REQ - 1;
    sbq.delete();
  endtask

  // One full transfer: request, accept check, programming check, response.
  task automatic applyStimulus(input logic [3:0] vmask, input int delay,
                               input bit keepValid, input bit stray);
    int   expId;
    int   lat;
    exp_t e;
    exp_t got;
    replyDelay = delay;
    req_valid  = vmask;
    expId      = rrPick(vmask);
    #1;
    lat = 0;
    while (req_ready == '0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (req_ready == '0) begin
      checkOutput("accept_wait", 0, 1);
      req_valid = '0;
      return;
    end
    checkOutput("req_ready", req_ready, 64'(1) << expId);
    e.id   = expId;
    e.tmo  = (delay < 1 || delay > TIMEOUT);
    e.data = e.tmo ? 8'h00 : (txByte[expId] ^ replyMask);
    sbq.push_back(e);
    @(negedge clk);
    if (!keepValid) req_valid = '0;
    if (stray) strayIrq = 1'b1;
    checkOutput("busy_t1", busy, 1);
    @(negedge clk);
    checkOutput("trans_en_t2", trans_en, 1);
    checkOutput("i_data_m", i_data_m, txByte[expId]);
    checkOutput("cfg_word", data_config_master, cfgWord[expId]);
    @(negedge clk);
    strayIrq = 1'b0;
    lat = 3;
    while (!rsp_valid && lat < TIMEOUT + 10) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("rsp_latency", lat, e.tmo ? 3 + TIMEOUT : 3 + delay);
    if (rsp_valid && sbq.size() > 0) begin
      got = sbq.pop_front();
      checkOutput("rsp_id", rsp_id, got.id);
      checkOutput("rsp_data", rsp_data, got.data);
      checkOutput("rsp_timeout", rsp_timeout, got.tmo);
      mLast = got.id;
    end else begin
      checkOutput("rsp_present", 0, 1);
    end
    checkOutput("busy_done", busy, 1);
    @(negedge clk);
    checkOutput("rsp_valid_pulse", rsp_valid, 0);
    checkOutput("busy_idle", busy, 0);
  endtask

  // Main sequence.
  initial begin
    int teStart;
    int rspBefore;
    int lat;
    rst        = 1'b1;
    req_valid  = '0;
    txByte[0]  = 8'h11; txByte[1]  = 8'hA5; txByte[2]  = 8'hC3; txByte[3]  = 8'h7E;
    cfgWord[0] = 32'hDEAD_0001; cfgWord[1] = 32'h0000_0103;
    cfgWord[2] = 32'h1234_5678; cfgWord[3] = 32'hCAFE_F00D;
    loadData();
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_trans_en", trans_en, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_i_data_m", i_data_m, 0);
    checkOutput("rst_cfg", data_config_master, 0);
    rst = 1'b0;

    replyMask = 8'h99;
    applyStimulus(4'b0010, 3, 1'b0, 1'b0);

    doReset();
    teStart = teCount;
    for (int k = 0; k < 8; k++) applyStimulus(4'b1111, 1 + (k % 3), k < 7, 1'b0);
    checkOutput("te_count_rr", teCount - teStart, 8);

    replyMask = 8'h5A;
    applyStimulus(4'b0100, 0, 1'b0, 1'b0);
    applyStimulus(4'b1000, 2, 1'b0, 1'b0);
    applyStimulus(4'b0001, TIMEOUT, 1'b0, 1'b0);
    applyStimulus(4'b0010, 5, 1'b0, 1'b1);
    applyStimulus(4'b0100, 1, 1'b0, 1'b0);

    replyDelay = 0;
    req_valid  = 4'b0010;
    #1;
    lat = 0;
    while (req_ready == '0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("mid_accept", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    repeat (5) @(negedge clk);
    checkOutput("mid_busy", busy, 1);
    rspBefore = rspCount;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_trans_en", trans_en, 0);
    checkOutput("mid_rst_rsp_valid", rsp_valid, 0);
    checkOutput("mid_rst_rsp", {rsp_id, rsp_data, rsp_timeout}, 0);
    checkOutput("mid_rst_i_data_m", i_data_m, 0);
    checkOutput("mid_rst_cfg", data_config_master, 0);
    checkOutput("mid_rst_ready", req_ready, 0);
    rst   = 1'b0;
    mLast = NUM_REQ - 1;
    repeat (TIMEOUT + 5) @(negedge clk);
    checkOutput("no_rsp_after_rst", rspCount, rspBefore);
    applyStimulus(4'b0101, 2, 1'b0, 1'b0);

    checkOutput("te_width", teWide, 0);
    checkOutput("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
